// File: rtl/generador_estado_if.sv
// Bus between the maintenance-count writer and its environment.
//   btn           raw maintenance button (asynchronous, bouncy)
//   clr           synchronous request to clear the count
//   estado_actual current count, fed back from the state register
//   estado        next-state value for the state register
//   evento        one-cycle pulse while estado carries an increment
//   alarma        registered threshold flag
//   sat           count is at 8'hFF
// master: the environment that owns the state register.
// slave:  the generador_estado writer.
interface generador_estado_if;
   logic       btn;
   logic       clr;
   logic [7:0] estado_actual;
   logic [7:0] estado;
   logic       evento;
   logic       alarma;
   logic       sat;

   modport master (
      output btn, clr, estado_actual,
      input  estado, evento, alarma, sat
   );

   modport slave (
      input  btn, clr, estado_actual,
      output estado, evento, alarma, sat
   );
endinterface

// File: rtl/generador_estado.sv
// Next-state writer for the 8-bit maintenance-count register.
// Debounces the maintenance button, issues one increment per accepted press,
// handles synchronous clear, and flags threshold and saturation.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    generador_estado_if.slave (btn, clr, estado_actual in;
//          estado, evento, alarma, sat out)
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | button released and stable
// DEB_PRESS | counting consecutive high samples toward a press
// PRESSED   | press accepted; holding never re-triggers
// DEB_REL   | counting consecutive low samples toward a release
module generador_estado #(
   parameter int         DEB_CYCLES = 4,
   parameter logic [7:0] UMBRAL     = 8'd10
) (
   input  logic                clk,
   input  logic                reset,
   generador_estado_if.slave   bus
);

   localparam int             CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           inc_q, inc_d;
   logic           clr_q;
   logic           sync_1, btn_s;
   logic           alarma_q;
   logic [8:0]     suma;

   // State register, synchronizer and registered flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1   <= 1'b0;
         btn_s    <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         inc_q    <= 1'b0;
         clr_q    <= 1'b0;
         alarma_q <= 1'b0;
      end else begin
         sync_1   <= bus.btn;
         btn_s    <= sync_1;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         inc_q    <= inc_d;
         clr_q    <= bus.clr;
         alarma_q <= (bus.estado_actual >= UMBRAL);
      end
   end

   // Next-state logic. The run counter restarts on every transition and
   // whenever a sample breaks the run; reaching CNT_LAST while seeing one
   // more matching sample completes DEB_CYCLES in a row.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn_s) begin
               if (DEB_CYCLES == 1) begin
                  state_d = PRESSED;
                  inc_d   = 1'b1;
               end else begin
                  state_d = DEB_PRESS;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         DEB_PRESS: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               inc_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            cnt_d = '0;
            if (!btn_s) begin
               if (DEB_CYCLES == 1) begin
                  state_d = IDLE;
               end else begin
                  state_d = DEB_REL;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         DEB_REL: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: clear beats increment; the increment is taken 9-bit and
   // clamped so the count never wraps.
   always_comb begin
      suma = {1'b0, bus.estado_actual} + 9'd1;
      if (clr_q)
         bus.estado = 8'h00;
      else if (inc_q)
         bus.estado = suma[8] ? 8'hFF : suma[7:0];
      else
         bus.estado = bus.estado_actual;
      bus.evento = inc_q & ~clr_q;
      bus.alarma = alarma_q;
      bus.sat    = (bus.estado_actual == 8'hFF);
   end

endmodule

// File: tb/tb_generador_estado.sv
module tb_generador_estado;
   localparam int         DEB = 4;
   localparam logic [7:0] UMB = 8'd10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   generador_estado_if bus();

   generador_estado #(.DEB_CYCLES(DEB), .UMBRAL(UMB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: accepted button level flips once the last DEB
   // synchronized samples all disagree with it; btn_s at edge e is btn at e-2.
   logic       hist[$];
   logic       samp[$];
   logic       acc;
   logic       inc_pend, clr_pend;
   logic [7:0] cnt_m;
   logic       alarm_m;
   int         ev_dut, ev_mod, cyc_bad;
   time        first_bad;

   task automatic model_reset();
      hist.delete();
      samp.delete();
      acc = 1'b0; inc_pend = 1'b0; clr_pend = 1'b0; alarm_m = 1'b0;
   endtask

   task automatic step(input logic b, input logic c);
      logic [7:0] est_pre, est_exp;
      logic       s, all_diff, ev_exp;
      bus.btn = b;
      bus.clr = c;
      est_pre = bus.estado;
      @(posedge clk);
      #1;
      bus.estado_actual = est_pre;
      alarm_m = (cnt_m >= UMB);
      if (clr_pend)      cnt_m = 8'h00;
      else if (inc_pend) cnt_m = (cnt_m == 8'hFF) ? 8'hFF : cnt_m + 8'd1;
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      s = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
      samp.push_back(s);
      if (samp.size() > 16) void'(samp.pop_front());
      inc_pend = 1'b0;
      if (samp.size() >= DEB) begin
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++)
            if (samp[samp.size()-1-k] == acc) all_diff = 1'b0;
         if (all_diff) begin
            acc = ~acc;
            inc_pend = acc;
         end
      end
      clr_pend = c;
      #1;
      est_exp = clr_pend ? 8'h00 :
                inc_pend ? ((cnt_m == 8'hFF) ? 8'hFF : cnt_m + 8'd1) : cnt_m;
      ev_exp  = inc_pend & ~clr_pend;
      if (ev_exp) ev_mod++;
      if (bus.evento === 1'b1) ev_dut++;
      if (bus.estado !== est_exp || bus.evento !== ev_exp ||
          bus.alarma !== alarm_m || bus.sat !== (cnt_m == 8'hFF) ||
          bus.estado_actual !== cnt_m) begin
         if (cyc_bad == 0) first_bad = $time;
         cyc_bad++;
      end
   endtask

   task automatic run(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   task automatic press(input int hi, input int lo);
      run(1'b1, hi);
      run(1'b0, lo);
   endtask

   task automatic load_reg(input logic [7:0] v);
      bus.estado_actual = v;
      cnt_m = v;
      #1;
   endtask

   task automatic begin_test();
      cyc_bad = 0; ev_dut = 0; ev_mod = 0; first_bad = 0;
   endtask

   task automatic test_reset();
      begin_test();
      bus.btn = 1'b0; bus.clr = 1'b0; bus.estado_actual = 8'h00;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.btn = ~bus.btn;
         @(posedge clk); #2;
         n_checks++;
         if (bus.estado !== 8'h00 || bus.evento !== 1'b0 || bus.alarma !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got estado=%0d evento=%0d alarma=%0d required 0/0/0",
                     bus.estado, bus.evento, bus.alarma);
         end
      end
      bus.btn = 1'b0;
      #1;
      reset = 1'b1;
      model_reset(); cnt_m = 8'h00;
      run(1'b1, 6);
      n_checks++;
      if (bus.evento !== 1'b1 || bus.estado_actual !== 8'h00) begin
         n_err++;
         $display("FAIL first_inc_latency: got evento=%0d count=%0d required 1/0 after edge 5",
                  bus.evento, bus.estado_actual);
      end
      step(1'b1, 1'b0);
      n_checks++;
      if (bus.estado_actual !== 8'h01) begin
         n_err++;
         $display("FAIL first_count_edge6: got %0d required 1", bus.estado_actual);
      end
      run(1'b1, 1);
      run(1'b0, 10);
      n_checks++;
      if (cyc_bad !== 0) begin
         n_err++;
         $display("FAIL reset_model: got %0d bad cycles (first at %0t) required 0", cyc_bad, first_bad);
      end
   endtask

   task automatic test_reset_mid_debounce();
      begin_test();
      run(1'b1, 4);
      #1 reset = 1'b0;
      bus.btn = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      run(1'b0, 12);
      n_checks++;
      if (bus.estado_actual !== 8'h01 || ev_dut !== 0) begin
         n_err++;
         $display("FAIL reset_mid_debounce: got count=%0d events=%0d required 1/0",
                  bus.estado_actual, ev_dut);
      end
   endtask

   task automatic test_bounce();
      logic [7:0] c0;
      begin_test();
      load_reg(8'h00);
      run(1'b1, 3);
      run(1'b0, 10);
      n_checks++;
      if (ev_dut !== 0 || bus.estado_actual !== 8'h00) begin
         n_err++;
         $display("FAIL glitch_only: got events=%0d count=%0d required 0/0", ev_dut, bus.estado_actual);
      end
      run(1'b1, 3); run(1'b0, 1); run(1'b1, 6); run(1'b0, 10);
      n_checks++;
      if (ev_dut !== 1 || bus.estado_actual !== 8'h01) begin
         n_err++;
         $display("FAIL bounce_single: got events=%0d count=%0d required 1/1", ev_dut, bus.estado_actual);
      end
      // randomized bounce bursts: short glitches then a solid press
      c0 = cnt_m;
      for (int r = 0; r < 6; r++) begin
         for (int g = 0; g < 3; g++) begin
            run(1'b1, $urandom_range(1, DEB - 1));
            run(1'b0, $urandom_range(1, 3));
         end
         run(1'b1, $urandom_range(DEB + 1, DEB + 8));
         for (int g = 0; g < 2; g++) begin
            run(1'b0, $urandom_range(1, DEB - 1));
            run(1'b1, $urandom_range(1, 2));
         end
         run(1'b0, DEB + 4);
      end
      n_checks++;
      if (bus.estado_actual !== c0 + 8'd6 || ev_dut !== 7) begin
         n_err++;
         $display("FAIL random_bounce: got count=%0d events=%0d required %0d/7",
                  bus.estado_actual, ev_dut, c0 + 8'd6);
      end
      n_checks++;
      if (cyc_bad !== 0) begin
         n_err++;
         $display("FAIL bounce_model: got %0d bad cycles (first at %0t) required 0", cyc_bad, first_bad);
      end
   endtask

   task automatic test_hold();
      begin_test();
      load_reg(8'h00);
      press(50, 10);
      n_checks++;
      if (ev_dut !== 1 || bus.estado_actual !== 8'h01) begin
         n_err++;
         $display("FAIL hold_single: got events=%0d count=%0d required 1/1", ev_dut, bus.estado_actual);
      end
      press(8, 10);
      n_checks++;
      if (bus.estado_actual !== 8'h02) begin
         n_err++;
         $display("FAIL hold_second: got %0d required 2", bus.estado_actual);
      end
   endtask

   task automatic test_threshold();
      int  guard;
      begin_test();
      load_reg(8'h00);
      run(1'b0, 2);
      guard = 0;
      bus.btn = 1'b1;
      while (bus.estado_actual !== 8'd10 && guard < 400) begin
         step((guard % 16) < 7, 1'b0);
         guard++;
      end
      n_checks++;
      if (guard >= 400) begin
         n_err++;
         $display("FAIL threshold_reach: got count=%0d required 10 within budget", bus.estado_actual);
      end
      n_checks++;
      if (bus.alarma !== 1'b0) begin
         n_err++;
         $display("FAIL alarma_lag: got %0d required 0 in cycle count reaches 10", bus.alarma);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (bus.alarma !== 1'b1) begin
         n_err++;
         $display("FAIL alarma_rise: got %0d required 1", bus.alarma);
      end
      run(1'b0, 10);
      step(1'b0, 1'b1);
      n_checks++;
      if (bus.estado !== 8'h00 || bus.estado_actual !== 8'd10) begin
         n_err++;
         $display("FAIL clr_next: got estado=%0d count=%0d required 0/10", bus.estado, bus.estado_actual);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (bus.estado_actual !== 8'h00 || bus.alarma !== 1'b1) begin
         n_err++;
         $display("FAIL clr_taken: got count=%0d alarma=%0d required 0/1", bus.estado_actual, bus.alarma);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (bus.alarma !== 1'b0) begin
         n_err++;
         $display("FAIL alarma_fall: got %0d required 0", bus.alarma);
      end
      n_checks++;
      if (cyc_bad !== 0) begin
         n_err++;
         $display("FAIL threshold_model: got %0d bad cycles (first at %0t) required 0", cyc_bad, first_bad);
      end
   endtask

   task automatic test_saturation();
      begin_test();
      load_reg(8'hFE);
      press(8, 10);
      n_checks++;
      if (bus.estado_actual !== 8'hFF || bus.sat !== 1'b1) begin
         n_err++;
         $display("FAIL sat_first: got count=%0d sat=%0d required 255/1", bus.estado_actual, bus.sat);
      end
      press(8, 10);
      n_checks++;
      if (bus.estado_actual !== 8'hFF || ev_dut !== 2) begin
         n_err++;
         $display("FAIL sat_hold: got count=%0d events=%0d required 255/2", bus.estado_actual, ev_dut);
      end
      n_checks++;
      if (cyc_bad !== 0) begin
         n_err++;
         $display("FAIL sat_model: got %0d bad cycles (first at %0t) required 0", cyc_bad, first_bad);
      end
   endtask

   task automatic test_collision();
      begin_test();
      load_reg(8'd5);
      run(1'b0, 2);
      run(1'b1, 5);
      step(1'b1, 1'b1);
      n_checks++;
      if (bus.estado !== 8'h00 || bus.evento !== 1'b0) begin
         n_err++;
         $display("FAIL collision: got estado=%0d evento=%0d required 0/0", bus.estado, bus.evento);
      end
      run(1'b1, 20);
      n_checks++;
      if (bus.estado_actual !== 8'h00 || ev_dut !== 0) begin
         n_err++;
         $display("FAIL collision_consumed: got count=%0d events=%0d required 0/0",
                  bus.estado_actual, ev_dut);
      end
      run(1'b0, 10);
      press(8, 10);
      n_checks++;
      if (bus.estado_actual !== 8'h01) begin
         n_err++;
         $display("FAIL collision_repress: got %0d required 1", bus.estado_actual);
      end
   endtask

   task automatic test_random();
      logic b;
      begin_test();
      load_reg(8'($urandom_range(0, 20)));
      b = 1'b0;
      for (int r = 0; r < 120; r++) begin
         b = ~b;
         for (int i = 0, n = $urandom_range(1, 8); i < n; i++)
            step(b, ($urandom_range(0, 15) == 0));
         if (r == 60) load_reg(8'hFC);
      end
      run(1'b0, 10);
      n_checks++;
      if (cyc_bad !== 0) begin
         n_err++;
         $display("FAIL random_model: got %0d bad cycles (first at %0t) required 0", cyc_bad, first_bad);
      end
      n_checks++;
      if (ev_dut !== ev_mod) begin
         n_err++;
         $display("FAIL random_events: got %0d required %0d", ev_dut, ev_mod);
      end
   endtask

   initial begin
      bus.btn = 1'b0;
      bus.clr = 1'b0;
      bus.estado_actual = 8'h00;
      cnt_m = 8'h00;
      model_reset();
      #2;
      test_reset();
      test_reset_mid_debounce();
      test_bounce();
      test_hold();
      test_threshold();
      test_saturation();
      test_collision();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/generador_estado.md
Name: generador_estado

Overview:
- Writer/next-state side of the 8-bit maintenance-count state register.
- Debounces a raw maintenance button and drives `estado`, the next-state value that the state register captures every clock.
- Reads the register's output back on `estado_actual`, and produces an increment event pulse, a threshold alarm and a saturation flag.

Parameters:
- DEB_CYCLES, 4: consecutive synchronized samples required to accept a press or a release (>=1).
- UMBRAL, 8'd10: maintenance count at or above which `alarma` asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn  in  1  raw maintenance button, asynchronous to clk, bouncy.
- clr  in  1  synchronous request to clear the count to zero.
- estado_actual  in  8  current count, fed back from the state register.
- estado  out  8  next-state value to the state register (combinational from registered flags and `estado_actual`).
- evento  out  1  one-cycle pulse; high during the cycle in which `estado` carries an increment.
- alarma  out  1  registered; high while the count is >= UMBRAL.
- sat  out  1  combinational; high when `estado_actual` == 8'hFF.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - Synchronizer flops, debounce counter, FSM (IDLE), inc_q, clr_q and alarma are all cleared.
  - Consequently `estado` = `estado_actual` and `evento` = 0.
  - A reset mid-debounce discards the press; no increment is issued.
- Synchronizer: btn passes through a 2-flop chain; btn_s is the output of flop 2. Only btn_s is used.
- Debounce counter:
  - Width is clog2(DEB_CYCLES+1).
  - Cleared on every FSM transition and on any sample that breaks a run.
- FSM states and transitions:
  - IDLE: on btn_s=1, go to DEB_PRESS with count=1. If DEB_CYCLES=1, accept immediately instead.
  - DEB_PRESS:
    - btn_s=0: return to IDLE, count cleared.
    - btn_s=1: count+1.
    - When the DEB_CYCLES-th consecutive 1 is sampled: go to PRESSED and set inc_q=1 for exactly one cycle.
  - PRESSED: on btn_s=0, go to DEB_REL with count=1. Holding the button never re-triggers.
  - DEB_REL:
    - btn_s=1: return to PRESSED.
    - On the DEB_CYCLES-th consecutive 0: go to IDLE.
- Latency (btn clean, rising before edge 0): btn_s=1 after edge 1, inc_q set at edge DEB_CYCLES+1, register captures the new count at edge DEB_CYCLES+2. With DEB_CYCLES=4, the count changes at edge 6.
- clr path:
  - clr_q <= clr each cycle.
  - clr high at edge k gives `estado` = 0 during cycle k..k+1; the register holds 0 after edge k+1.
- Next-state mux (priority order):
  - clr_q=1: `estado` = 8'h00.
  - else inc_q=1: `estado` = `estado_actual`+1, saturating, so 8'hFF stays 8'hFF.
  - else: `estado` = `estado_actual` (hold).
- evento = inc_q AND NOT clr_q.
- clr and inc coinciding: clear wins, evento=0, and the press is consumed (FSM still enters PRESSED).
- Saturation: at 8'hFF an accepted press still pulses evento, but `estado` stays 8'hFF; sat=1.
- Threshold: alarma <= (`estado_actual` >= UMBRAL) every cycle, so it lags `estado_actual` by one cycle. It deasserts one cycle after a clear takes effect.
- Arithmetic: 8-bit unsigned; the increment is computed 9-bit and clamped. No wrap-around ever occurs.

Test Plan:
- Reset: reset=0 with estado_actual=8'h00, btn toggling -> estado=8'h00, evento=0, alarma=0. After release, an 8-cycle btn=1 pulse -> count 1 at edge 6.
- Bounce: btn high 3 cycles, low 1, high 6, low 10 (DEB_CYCLES=4) -> exactly one evento pulse, count 0 -> 1. The 3-cycle glitch alone produces nothing.
- Hold: btn held 50 cycles, then released 10 -> a single increment. A second clean press -> count 2.
- Threshold: 10 clean presses from 0 (UMBRAL=10) -> alarma rises one cycle after estado_actual reaches 8'd10. Then clr=1 for one cycle -> estado=0, count 0 next edge, alarma falls one cycle later.
- Saturation: force the register to 8'hFE, then give two clean presses -> count 8'hFF, then stays 8'hFF. evento pulses twice; sat=1 after the first.
- Collision: clr asserted so that clr_q coincides with inc_q -> estado=8'h00, evento=0. No further increment until the button is released and pressed again.
